// File: rtl/instr_fetch_cache.sv
// instr_fetch_cache: fetch stage with a small fully-associative, round-robin instruction cache
module instr_fetch_cache #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_ENTRIES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [7:0]                       hit_count,
    output logic [7:0]                       miss_count
);
    localparam int VW = $clog2(CACHE_ENTRIES);
    localparam logic [2:0] IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010;
    localparam logic [2:0] FETCH = 3'b001, DECODE = 3'b010;

    logic [2:0] state, next_state;
    logic [CACHE_ENTRIES-1:0] valid, hit_vec;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] tag [CACHE_ENTRIES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] word [CACHE_ENTRIES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_word;
    logic [VW-1:0] vptr, victim;
    logic lookup, hit, fill;

    // Scanning downward leaves victim on the lowest invalid entry, or vptr when all are valid.
    always_comb begin
        hit_vec = '0;
        hit_word = '0;
        victim = vptr;
        for (int i = CACHE_ENTRIES - 1; i >= 0; i--) begin
            hit_vec[i] = valid[i] && tag[i] == current_pc;
            hit_word = hit_word | (hit_vec[i] ? word[i] : '0);
            victim = valid[i] ? victim : VW'(i);
        end
    end

    always_comb begin
        lookup = state == IDLE && core_state == FETCH;
        hit = |hit_vec;
        fill = state == FETCHING && mem_read_ready;
    end

    always_ff @(posedge clk)
        state <= !reset ? IDLE : next_state;

    always_comb
        next_state = state == IDLE     ? (lookup ? (hit ? FETCHED : FETCHING) : IDLE) :
                     state == FETCHING ? (mem_read_ready ? FETCHED : FETCHING) :
                     state == FETCHED  ? (core_state == DECODE ? IDLE : FETCHED) : IDLE;

    always_comb
        fetcher_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            instruction <= '0;
            hit_count <= '0;
            miss_count <= '0;
            valid <= '0;
            vptr <= '0;
        end else begin
            if (lookup && hit) begin
                instruction <= hit_word;
                hit_count <= hit_count + 8'(hit_count != 8'hFF);
            end
            if (lookup && !hit) begin
                mem_read_valid <= 1'b1;
                mem_read_address <= current_pc;
                miss_count <= miss_count + 8'(miss_count != 8'hFF);
            end
            if (fill) begin
                mem_read_valid <= 1'b0;
                instruction <= mem_read_data;
            end
            // A concurrent flush wins: the returned word is delivered but not cached.
            if (fill && !flush) begin
                valid[victim] <= 1'b1;
                tag[victim] <= mem_read_address;
                word[victim] <= mem_read_data;
                vptr <= &valid ? vptr + VW'(1) : vptr;
            end
            if (flush) begin
                valid <= '0;
                vptr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_cache.sv
// tb_instr_fetch_cache: directed fetch scenarios checked against a transaction-level cache model
module tb_instr_fetch_cache;
    localparam int A = 8, D = 16, N = 4;
    localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

    logic clk = 0, reset = 0, flush = 0, mem_read_ready = 0;
    logic [2:0] core_state = 3'b000;
    logic [A-1:0] current_pc = '0;
    logic [D-1:0] mem_read_data = '0;
    logic mem_read_valid;
    logic [A-1:0] mem_read_address;
    logic [2:0] fetcher_state;
    logic [D-1:0] instruction;
    logic [7:0] hit_count, miss_count;

    always #5 clk = ~clk;

    instr_fetch_cache #(.PROGRAM_MEM_ADDR_BITS(A), .PROGRAM_MEM_DATA_BITS(D), .CACHE_ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state), .instruction(instruction),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int checks = 0, errors = 0, vcycles = 0;
    logic [A-1:0] m_tag [N];
    bit m_val [N];
    int m_vp;
    logic [2:0] e_state;
    logic e_valid;
    logic [A-1:0] e_addr;
    logic [D-1:0] e_instr;
    int e_hits, e_miss;
    bit chk_en = 0;

    function automatic logic [D-1:0] img(input logic [A-1:0] pc);
        return pc == 8'h05 ? 16'hA1B2 : pc == 8'h10 ? 16'h1234 : {pc ^ 8'h5A, pc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int m_find(input logic [A-1:0] pc);
        for (int i = 0; i < N; i++) if (m_val[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic m_fill(input logic [A-1:0] pc);
        for (int i = 0; i < N; i++)
            if (!m_val[i]) begin
                m_val[i] = 1;
                m_tag[i] = pc;
                return;
            end
        m_tag[m_vp] = pc;
        m_vp = (m_vp + 1) % N;
    endtask

    task automatic m_flush();
        for (int i = 0; i < N; i++) m_val[i] = 0;
        m_vp = 0;
    endtask

    task automatic m_reset();
        m_flush();
        e_state = S_IDLE;
        e_valid = 0;
        e_addr = '0;
        e_instr = '0;
        e_hits = 0;
        e_miss = 0;
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("fetcher_state", 32'(fetcher_state), 32'(e_state));
            check("mem_read_valid", 32'(mem_read_valid), 32'(e_valid));
            if (e_valid) check("mem_read_address", 32'(mem_read_address), 32'(e_addr));
            check("instruction", 32'(instruction), 32'(e_instr));
            check("hit_count", 32'(hit_count), 32'(e_hits > 255 ? 255 : e_hits));
            check("miss_count", 32'(miss_count), 32'(e_miss > 255 ? 255 : e_miss));
            if (mem_read_valid) vcycles++;
        end
    end

    task automatic fetch(input logic [A-1:0] pc, input int waits, input bit flush_on_ready);
        int idx;
        idx = m_find(pc);
        @(negedge clk);
        core_state = 3'b001;
        current_pc = pc;
        vcycles = 0;
        @(posedge clk);
        if (idx >= 0) begin
            e_state = S_FETCHED;
            e_instr = img(pc);
            e_hits++;
        end else begin
            e_state = S_FETCHING;
            e_valid = 1;
            e_addr = pc;
            e_miss++;
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                mem_read_ready = w == waits;
                mem_read_data = w == waits ? img(pc) : 16'hDEAD;
                flush = flush_on_ready && w == waits;
                @(posedge clk);
            end
            e_state = S_FETCHED;
            e_valid = 0;
            e_instr = img(pc);
            if (flush_on_ready) m_flush(); else m_fill(pc);
            @(negedge clk);
            mem_read_ready = 0;
            flush = 0;
            @(posedge clk);
        end
        @(negedge clk);
        core_state = 3'b010;
        @(posedge clk);
        e_state = S_IDLE;
        @(negedge clk);
        core_state = 3'b000;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 1;
        check("reset_state", 32'(fetcher_state), 32'(3'b000));
        check("reset_valid", 32'(mem_read_valid), 32'(0));
        check("reset_counts", 32'({hit_count, miss_count}), 32'(0));

        fetch(8'h05, 3, 0);
        check("t1_valid_cycles", 32'(vcycles), 32'(4));
        check("t1_instr", 32'(instruction), 32'(16'hA1B2));
        check("t1_miss_count", 32'(miss_count), 32'(1));

        fetch(8'h05, 0, 0);
        check("t2_valid_cycles", 32'(vcycles), 32'(0));
        check("t2_instr", 32'(instruction), 32'(16'hA1B2));
        check("t2_hit_count", 32'(hit_count), 32'(1));

        @(negedge clk);
        flush = 1;
        @(posedge clk);
        m_flush();
        @(negedge clk);
        flush = 0;
        for (int p = 0; p < 5; p++) fetch(8'(p), p % 3, 0);
        fetch(8'h00, 1, 0);
        check("t3_evict_miss", 32'(miss_count), 32'(7));
        fetch(8'h02, 0, 0);
        check("t3_keep_hit", 32'(hit_count), 32'(2));

        fetch(8'h10, 1, 1);
        check("t4_instr", 32'(instruction), 32'(16'h1234));
        fetch(8'h10, 0, 0);
        check("t4_refetch_miss", 32'(miss_count), 32'(9));

        @(negedge clk);
        core_state = 3'b001;
        current_pc = 8'h20;
        @(posedge clk);
        e_state = S_FETCHING;
        e_valid = 1;
        e_addr = 8'h20;
        e_miss++;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        reset = 1;
        core_state = 3'b000;
        mem_read_ready = 1;
        mem_read_data = 16'hFFFF;
        @(negedge clk);
        mem_read_ready = 0;
        check("t5_valid", 32'(mem_read_valid), 32'(0));
        check("t5_state", 32'(fetcher_state), 32'(3'b000));
        check("t5_counts", 32'({hit_count, miss_count}), 32'(0));
        check("t5_instr", 32'(instruction), 32'(0));

        fetch(8'h30, 0, 0);
        for (int k = 0; k < 300; k++) fetch(8'h30, 0, 0);
        check("t6_hit_sat", 32'(hit_count), 32'(255));
        check("t6_miss_count", 32'(miss_count), 32'(1));

        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
